serial_frame_router: RTL and testbench
======================================

Name: serial_frame_router

Overview:
Parametrised serial frame receiver and router. It hunts a bit-serial stream for a configurable start pattern, then captures an address field and a length field. It then passes the payload bits through to one of 2**ADDR_W output channels. Clocked by the system clock and gated by a clock-enable strobe. It sits between the serial input pin logic and the per-channel consumers. The internal payload counter replaces an external counter.

Parameters:
PATTERN_W, 4, start-pattern width in bits (>=2)
PATTERN, 4'b1011, start pattern, first received bit is MSB
ADDR_W, 2, address field width (>=1); channel count = 2**ADDR_W
LEN_W, 4, length field width (>=1); payload length = field+1 bits

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
clk_en  input  1  bit strobe; all state/counter updates only when high
ser_in  input  1  serial data in
ser_out  output  1  serial data out, combinationally equal to ser_in
ser_out_valid  output  2**ADDR_W  one-hot; bit [channel] high while payload is passing
channel  output  ADDR_W  captured address of current/last frame
busy  output  1  high in any state other than HUNT
frame_done  output  1  one-cycle pulse on the last payload bit

Behaviour:
- Reset (async, rst=1): state=HUNT, hunt shift reg=0, addr_reg=0, len_reg=0, bit counter=0. Outputs: ser_out_valid=0, channel=0, busy=0, frame_done=0. ser_out follows ser_in.
- All registers update only on rising clk with clk_en=1. With clk_en=0, every register holds.
- States: HUNT, ADDR, LEN, DATA.
- HUNT:
  - On each enabled edge: hunt_sr <= {hunt_sr[PATTERN_W-2:0], ser_in}.
  - If {hunt_sr[PATTERN_W-2:0], ser_in} == PATTERN: go to ADDR, bit counter=0.
  - Overlapping patterns are detected because the shift register is not flushed on partial mismatch.
- ADDR:
  - Shift ser_in into addr_reg MSB first; counter increments.
  - On the ADDR_W-th bit: go to LEN, counter=0.
- LEN:
  - Shift ser_in into len_reg MSB first.
  - On the LEN_W-th bit: go to DATA, counter=0.
- DATA:
  - ser_out_valid[addr_reg]=1 (Moore, combinational from state; valid regardless of clk_en, consumers sample on clk_en).
  - Counter increments per enabled bit.
  - When clk_en=1 and counter==len_reg: frame_done=1 that cycle (combinational), go to HUNT, hunt_sr cleared to 0.
- Payload bits are never fed to the hunt register. A pattern embedded in the payload is ignored.
- Address and length bits do not assert any valid.
- channel = addr_reg at all times. The captured address holds after the frame until the next ADDR capture completes.
- Counter width = max(clog2(ADDR_W), clog2(LEN_W), LEN_W)+1; no wrap is possible.
- len_reg=0 gives a 1-bit payload. len_reg=2**LEN_W-1 gives 2**LEN_W bits.
- Back-to-back frames: HUNT restarts from a cleared register, so the next pattern needs all PATTERN_W fresh bits.
- Reset asserted mid-frame: all valids drop asynchronously in the same cycle, with no frame_done. The partial frame is discarded.
- Only these outputs are combinational: ser_out, ser_out_valid, frame_done, busy. All other state is registered.

Test Plan:
- Defaults, clk_en=1: stream 1011 10 0011 d0..d3 -> after last len bit, ser_out_valid=4'b0100 for exactly 4 cycles, ser_out==ser_in, frame_done high on the d3 cycle only, channel=2, then busy=0.
- Overlap: stream 1 1 0 1 1 01 0000 x -> pattern found ending at bit 5, channel=1, single-bit payload, valid=4'b0010 one cycle with frame_done same cycle.
- clk_en toggling 1/0 each cycle with the first frame -> valid held for 8 clk cycles (4 enabled). No state change on clk_en=0 cycles. frame_done only in the enabled cycle of d3.
- Payload containing 1011 (len=7, payload 10111011) then a new full frame to channel 3 -> no re-trigger inside payload; second frame routed to valid=4'b1000.
- Async reset pulse (between clock edges) during DATA of a channel-2 frame -> valid=0 immediately, busy=0, channel=0, no frame_done. Following complete frame is received correctly.
- Max length: len=1111 -> exactly 16 valid enabled bits, counter no wrap, frame_done on 16th.

Source files
------------

// File: rtl/serial_frame_router.sv
// serial_frame_router
//
// Hunts a bit-serial stream for a start pattern. It then captures an address
// field and a length field, both MSB first. After that it flags the payload
// bits as valid on the addressed output channel. The payload itself is never
// registered: ser_out is a straight wire from ser_in, and consumers qualify it
// with their one-hot valid bit and clk_en.
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous active-high reset
//   clk_en        bit strobe; every register advances only when high
//   ser_in        serial data in
//   ser_out       serial data out (combinational copy of ser_in)
//   ser_out_valid one-hot per channel, high while payload is passing
//   channel       captured address of the current/last frame
//   busy          high whenever a frame is being received (state != HUNT)
//   frame_done    one-cycle pulse on the enabled cycle of the last payload bit

module serial_frame_router #(
    parameter int                   PATTERN_W = 4,
    parameter logic [PATTERN_W-1:0] PATTERN   = 4'b1011,
    parameter int                   ADDR_W    = 2,
    parameter int                   LEN_W     = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clk_en,
    input  logic                   ser_in,
    output logic                   ser_out,
    output logic [2**ADDR_W-1:0]   ser_out_valid,
    output logic [ADDR_W-1:0]      channel,
    output logic                   busy,
    output logic                   frame_done
);

    localparam int CLOG_A = $clog2(ADDR_W);
    localparam int CLOG_L = $clog2(LEN_W);
    localparam int MAX_AL = (CLOG_A > CLOG_L) ? CLOG_A : CLOG_L;
    // One spare bit so the counter cannot wrap, even for a maximum-length payload.
    localparam int CNT_W  = ((MAX_AL > LEN_W) ? MAX_AL : LEN_W) + 1;

    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] LEN_LAST  = CNT_W'(LEN_W - 1);

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_ADDR,
        ST_LEN,
        ST_DATA
    } state_t;

    state_t               state_q, state_d;
    logic [PATTERN_W-1:0] hunt_q,  hunt_d;
    logic [ADDR_W-1:0]    addr_q,  addr_d;
    logic [LEN_W-1:0]     len_q,   len_d;
    logic [CNT_W-1:0]     cnt_q,   cnt_d;

    // Window including the bit currently on the wire. It is used for matching
    // so that the pattern is recognised on the edge that shifts in its last bit.
    logic [PATTERN_W-1:0] hunt_shift;

    assign hunt_shift = {hunt_q[PATTERN_W-2:0], ser_in};
    assign ser_out    = ser_in;
    assign channel    = addr_q;
    assign busy       = (state_q != ST_HUNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_HUNT;
            hunt_q  <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
        end else if (clk_en) begin
            state_q <= state_d;
            hunt_q  <= hunt_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        hunt_d        = hunt_q;
        addr_d        = addr_q;
        len_d         = len_q;
        cnt_d         = cnt_q;
        ser_out_valid = '0;
        frame_done    = 1'b0;

        unique case (state_q)
            ST_HUNT: begin
                hunt_d = hunt_shift;
                if (hunt_shift == PATTERN) begin
                    state_d = ST_ADDR;
                    cnt_d   = '0;
                end
            end

            ST_ADDR: begin
                // Truncating the concatenation drops the old MSB: shift-in, MSB first.
                addr_d = ADDR_W'({addr_q, ser_in});
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == ADDR_LAST) begin
                    state_d = ST_LEN;
                    cnt_d   = '0;
                end
            end

            ST_LEN: begin
                len_d = LEN_W'({len_q, ser_in});
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LEN_LAST) begin
                    state_d = ST_DATA;
                    cnt_d   = '0;
                end
            end

            ST_DATA: begin
                // Valid is a Moore output: it stays high through clk_en-low cycles.
                ser_out_valid[addr_q] = 1'b1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(len_q)) begin
                    // frame_done is qualified by clk_en because the last bit
                    // is only consumed on an enabled cycle.
                    frame_done = clk_en;
                    state_d    = ST_HUNT;
                    hunt_d     = '0;
                    cnt_d      = '0;
                end
            end

            default: begin
                state_d = ST_HUNT;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_frame_router.sv
// Testbench for serial_frame_router.
// Frames are described at frame level: noise, start pattern, address, length
// and payload. The expected per-bit outputs are derived from that description.
module tb_serial_frame_router;

    localparam int                   PATTERN_W = 4;
    localparam logic [PATTERN_W-1:0] PATTERN   = 4'b1011;
    localparam int                   ADDR_W    = 2;
    localparam int                   LEN_W     = 4;
    localparam int                   NCH       = 2**ADDR_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              clk_en;
    logic              ser_in;
    logic              ser_out;
    logic [NCH-1:0]    ser_out_valid;
    logic [ADDR_W-1:0] channel;
    logic              busy;
    logic              frame_done;

    serial_frame_router #(
        .PATTERN_W(PATTERN_W),
        .PATTERN  (PATTERN),
        .ADDR_W   (ADDR_W),
        .LEN_W    (LEN_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .clk_en       (clk_en),
        .ser_in       (ser_in),
        .ser_out      (ser_out),
        .ser_out_valid(ser_out_valid),
        .channel      (channel),
        .busy         (busy),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Address the model believes the DUT has most recently captured.
    logic [ADDR_W-1:0] last_ch = '0;

    // Noise bits sent in HUNT ahead of the start pattern.
    bit noise_q[$];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle between edges, then check the combinational outputs
    // before the next rising edge.
    task automatic applyStimulus(input logic b, input logic en, input logic exp_busy,
                                 input logic [NCH-1:0] exp_valid, input logic exp_done,
                                 input logic chk_ch);
        @(negedge clk);
        ser_in = b;
        clk_en = en;
        #1;
        checkOutput("ser_out", 32'(ser_out), 32'(b));
        checkOutput("busy", 32'(busy), 32'(exp_busy));
        checkOutput("valid", 32'(ser_out_valid), 32'(exp_valid));
        checkOutput("frame_done", 32'(frame_done), 32'(exp_done & en));
        if (chk_ch) checkOutput("channel", 32'(channel), 32'(last_ch));
    endtask

    // One enabled bit, preceded by disabled cycles: mode 0 none, 1 exactly one, 2 random 0..2.
    task automatic sendBit(input logic b, input int mode, input logic exp_busy,
                           input logic [NCH-1:0] exp_valid, input logic exp_done,
                           input logic chk_ch);
        int gaps;
        gaps = (mode == 0) ? 0 : (mode == 1) ? 1 : int'($urandom_range(2));
        for (int g = 0; g < gaps; g++)
            applyStimulus(1'($urandom_range(1)), 1'b0, exp_busy, exp_valid, 1'b0, chk_ch);
        applyStimulus(b, 1'b1, exp_busy, exp_valid, exp_done, chk_ch);
    endtask

    // True if noise followed by the pattern would complete a match before the
    // pattern's last bit. The search starts from an all-zero history.
    function automatic bit triggersEarly();
        bit s[$];
        bit hit;
        logic [PATTERN_W-1:0] pat;
        pat = PATTERN;
        for (int i = 0; i < PATTERN_W - 1; i++) s.push_back(1'b0);
        foreach (noise_q[i]) s.push_back(noise_q[i]);
        for (int i = 0; i < PATTERN_W; i++) s.push_back(pat[PATTERN_W-1-i]);
        for (int e = PATTERN_W - 1; e < s.size() - 1; e++) begin
            hit = 1'b1;
            for (int k = 0; k < PATTERN_W; k++)
                if (s[e-PATTERN_W+1+k] != pat[PATTERN_W-1-k]) hit = 1'b0;
            if (hit) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic makeNoise();
        int n;
        do begin
            noise_q.delete();
            n = int'($urandom_range(6));
            for (int i = 0; i < n; i++) noise_q.push_back(1'($urandom_range(1)));
        end while (triggersEarly());
    endtask

    // Send noise, pattern, address, length and payload. If abort_at >= 0,
    // reset is pulsed between edges during that payload bit instead of finishing.
    task automatic sendFrame(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l,
                             input logic [15:0] payload, input int mode, input int abort_at);
        logic [PATTERN_W-1:0] pat;
        logic [NCH-1:0] onehot;
        pat    = PATTERN;
        onehot = NCH'(1) << a;
        foreach (noise_q[i]) sendBit(noise_q[i], mode, 1'b0, '0, 1'b0, 1'b1);
        for (int i = PATTERN_W - 1; i >= 0; i--) sendBit(pat[i], mode, 1'b0, '0, 1'b0, 1'b1);
        for (int i = ADDR_W - 1; i >= 0; i--) sendBit(a[i], mode, 1'b1, '0, 1'b0, 1'b0);
        last_ch = a;
        for (int i = LEN_W - 1; i >= 0; i--) sendBit(l[i], mode, 1'b1, '0, 1'b0, 1'b1);
        for (int i = 0; i <= int'(l); i++) begin
            if (i == abort_at) begin
                @(negedge clk);
                ser_in = payload[i];
                clk_en = 1'b1;
                #2 rst = 1'b1;
                #1;
                last_ch = '0;
                checkOutput("abort_valid", 32'(ser_out_valid), 32'd0);
                checkOutput("abort_busy", 32'(busy), 32'd0);
                checkOutput("abort_channel", 32'(channel), 32'(last_ch));
                checkOutput("abort_done", 32'(frame_done), 32'd0);
                #1 rst = 1'b0;
                return;
            end
            sendBit(payload[i], mode, 1'b1, onehot, (i == int'(l)), 1'b1);
        end
    endtask

    initial begin
        rst    = 1'b1;
        clk_en = 1'b0;
        ser_in = 1'b0;
        #12;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_valid", 32'(ser_out_valid), 32'd0);
        checkOutput("rst_channel", 32'(channel), 32'd0);
        checkOutput("rst_done", 32'(frame_done), 32'd0);
        ser_in = 1'b1;
        #1;
        checkOutput("rst_ser_out", 32'(ser_out), 32'd1);
        @(negedge clk);
        rst = 1'b0;

        // Basic frame to channel 2, 4-bit payload.
        noise_q.delete();
        sendFrame(2'd2, 4'd3, 16'($urandom), 0, -1);

        // Overlapping start: 1 1 0 1 1 finds the pattern ending at bit 5.
        noise_q.delete();
        noise_q.push_back(1'b1);
        sendFrame(2'd1, 4'd0, 16'h0000, 0, -1);

        // clk_en alternating low/high.
        noise_q.delete();
        sendFrame(2'd2, 4'd3, 16'($urandom), 1, -1);

        // Payload that contains the pattern must not re-trigger.
        noise_q.delete();
        sendFrame(2'd0, 4'd7, 16'b1101_1101, 0, -1);
        noise_q.delete();
        sendFrame(2'd3, 4'd2, 16'($urandom), 0, -1);

        // Reset during DATA, followed by a clean frame.
        noise_q.delete();
        sendFrame(2'd2, 4'd5, 16'($urandom), 0, 3);
        noise_q.delete();
        sendFrame(2'd1, 4'd1, 16'($urandom), 0, -1);

        // Maximum-length payload.
        noise_q.delete();
        sendFrame(2'd3, 4'd15, 16'($urandom), 0, -1);

        // Randomised frames with noise and clk_en gaps.
        for (int f = 0; f < 20; f++) begin
            makeNoise();
            sendFrame(ADDR_W'($urandom), LEN_W'($urandom), 16'($urandom), 2, -1);
        end

        // Idle after the last frame: back in HUNT.
        applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
